rv32_mc_sequencer: RTL and testbench

Multi-cycle control and sequencing block for the RV32I core. It replaces the single-cycle, always-ready memory timing with a state machine that uses ready/valid handshakes to instruction and data memory. It owns the PC, IR and load-data registers and the retired-instruction counter. It sequences the existing combinational decode/ALU/immediate datapath through FETCH, EXEC, MEM and WB, and traps on misalignment, illegal opcode or memory timeout.

---
 rtl/rv32_mc_pkg.sv | 36 +++
 rtl/rv32_wait_timer.sv | 29 ++
 rtl/rv32_mc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_rv32_mc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mc_pkg.sv
// rtl/rv32_mc_pkg.sv - shared types and constants for the RV32I multi-cycle sequencer
package rv32_mc_pkg;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      EXEC  = 3'd1,
      MEM   = 3'd2,
      WB    = 3'd3,
      TRAP  = 3'd4
   } state_t;

   localparam logic [1:0] TRAP_NONE     = 2'd0;
   localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
   localparam logic [1:0] TRAP_MISALIGN = 2'd2;
   localparam logic [1:0] TRAP_TIMEOUT  = 2'd3;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Major opcodes, kept here so the control unit and sequencer agree on them.
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   function automatic logic misaligned(input logic [1:0] lsbs);
      return lsbs != 2'b00;
   endfunction

endpackage

// File: rtl/rv32_wait_timer.sv
// rtl/rv32_wait_timer.sv - memory-ready wait counter with optional timeout
module rv32_wait_timer #(
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   input  logic enable,
   output logic timeout
);

   localparam int unsigned LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

   logic [TO_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && tick) begin
         count <= count + TO_W'(1);
      end
   end

   // Fires during the wait cycle that brings the count up to MEM_TIMEOUT.
   assign timeout = (MEM_TIMEOUT != 0) && enable && tick && (count == TO_W'(LAST));

endmodule

// File: rtl/rv32_mc_sequencer.sv
// rtl/rv32_mc_sequencer.sv - multi-cycle FETCH/EXEC/MEM/WB sequencer with trap handling
module rv32_mc_sequencer
   import rv32_mc_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              CNT_W       = 32,
   parameter int              MEM_TIMEOUT = 0,
   parameter int              TO_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   input  logic             dmem_ready,
   input  logic [31:0]      dmem_rdata,
   input  logic             ctl_load,
   input  logic             ctl_store,
   input  logic             ctl_branch,
   input  logic             ctl_jal,
   input  logic             ctl_jalr,
   input  logic             ctl_reg_write,
   input  logic             ctl_illegal,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  alu_res,
   output logic [XLEN-1:0]  pc,
   output logic [31:0]      ir,
   output logic [31:0]      ld_data,
   output logic             reg_we,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic [1:0]       trap_cause
);

   state_t          state;
   logic [XLEN-1:0] next_pc;
   logic            next_misaligned;
   logic            wb_we;
   logic            timer_clear;
   logic            timer_tick;
   logic            timer_enable;
   logic            timer_timeout;

   assign imem_addr = pc;

   always_comb begin
      next_pc = pc + XLEN'(4);
      if (ctl_jalr) begin
         next_pc = alu_res & ~XLEN'(1);
      end else if (ctl_jal || (ctl_branch && br_taken)) begin
         next_pc = alu_res;
      end
   end

   assign next_misaligned = misaligned(next_pc[1:0]);
   assign wb_we = ctl_reg_write & ~ctl_store & ~(ctl_branch & ~ctl_jal & ~ctl_jalr);

   // Clearing while in EXEC/WB guarantees a zero count on entry to MEM/FETCH.
   assign timer_clear  = (state == EXEC) || (state == WB) || ((state == FETCH) && !imem_req);
   assign timer_enable = ((state == FETCH) && imem_req) || (state == MEM);
   assign timer_tick   = (state == FETCH) ? ~imem_ready : ~dmem_ready;

   rv32_wait_timer #(
      .TO_W        (TO_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .tick    (timer_tick),
      .enable  (timer_enable),
      .timeout (timer_timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         ir         <= NOP_INSTR;
         ld_data    <= '0;
         dmem_addr  <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         reg_we     <= 1'b0;
         instret    <= '0;
         halted     <= 1'b0;
         trap_cause <= TRAP_NONE;
      end else begin
         reg_we <= 1'b0;
         case (state)
            FETCH: begin
               // imem_req is low only in the first cycle after reset.
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ready) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= EXEC;
               end else if (timer_timeout) begin
                  imem_req   <= 1'b0;
                  halted     <= 1'b1;
                  trap_cause <= TRAP_TIMEOUT;
                  state      <= TRAP;
               end
            end
            EXEC: begin
               if (ctl_illegal) begin
                  halted     <= 1'b1;
                  trap_cause <= TRAP_ILLEGAL;
                  state      <= TRAP;
               end else if (ctl_load || ctl_store) begin
                  dmem_addr <= alu_res;
                  dmem_req  <= 1'b1;
                  dmem_we   <= ctl_store;
                  state     <= MEM;
               end else begin
                  reg_we <= wb_we & ~next_misaligned;
                  state  <= WB;
               end
            end
            MEM: begin
               if (dmem_ready) begin
                  if (ctl_load) begin
                     ld_data <= dmem_rdata;
                  end
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  reg_we   <= wb_we & ~next_misaligned;
                  state    <= WB;
               end else if (timer_timeout) begin
                  dmem_req   <= 1'b0;
                  dmem_we    <= 1'b0;
                  halted     <= 1'b1;
                  trap_cause <= TRAP_TIMEOUT;
                  state      <= TRAP;
               end
            end
            WB: begin
               if (next_misaligned) begin
                  halted     <= 1'b1;
                  trap_cause <= TRAP_MISALIGN;
                  state      <= TRAP;
               end else begin
                  pc       <= next_pc;
                  instret  <= instret + CNT_W'(1);
                  imem_req <= 1'b1;
                  state    <= FETCH;
               end
            end
            TRAP: begin
               state <= TRAP;
            end
            default: begin
               halted <= 1'b1;
               state  <= TRAP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv32_mc_sequencer.sv
// tb/tb_rv32_mc_sequencer.sv - directed scoreboard bench for rv32_mc_sequencer
module tb_rv32_mc_sequencer;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        ctl_load, ctl_store, ctl_branch, ctl_jal, ctl_jalr, ctl_reg_write, ctl_illegal;
   logic        br_taken;
   logic [31:0] alu_res;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] ld_data;
   logic        reg_we;
   logic [31:0] instret;
   logic        halted;
   logic [1:0]  trap_cause;

   rv32_mc_sequencer #(
      .XLEN        (32),
      .RESET_PC    (32'h0000_0000),
      .CNT_W       (32),
      .MEM_TIMEOUT (4),
      .TO_W        (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_ready    (dmem_ready),
      .dmem_rdata    (dmem_rdata),
      .ctl_load      (ctl_load),
      .ctl_store     (ctl_store),
      .ctl_branch    (ctl_branch),
      .ctl_jal       (ctl_jal),
      .ctl_jalr      (ctl_jalr),
      .ctl_reg_write (ctl_reg_write),
      .ctl_illegal   (ctl_illegal),
      .br_taken      (br_taken),
      .alu_res       (alu_res),
      .pc            (pc),
      .ir            (ir),
      .ld_data       (ld_data),
      .reg_we        (reg_we),
      .instret       (instret),
      .halted        (halted),
      .trap_cause    (trap_cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cls bits: {illegal, reg_write, jalr, jal, branch, store, load}
   localparam logic [6:0] C_ALU  = 7'b0100000;
   localparam logic [6:0] C_LD   = 7'b0100001;
   localparam logic [6:0] C_ST   = 7'b0000010;
   localparam logic [6:0] C_BRW  = 7'b0100100;
   localparam logic [6:0] C_JAL  = 7'b0101000;
   localparam logic [6:0] C_JALR = 7'b0110000;
   localparam logic [6:0] C_ILL  = 7'b1000000;

   typedef struct {
      logic [31:0] word;
      logic [6:0]  cls;
      logic        taken;
      logic [31:0] alu;
      int          iw;
      int          dw;
      logic [31:0] rdata;
   } instr_t;

   typedef struct {
      logic        we;
      logic [31:0] ld;
      int          cycles;
   } wb_exp_t;

   logic [31:0] fetch_q[$];
   wb_exp_t     wb_q[$];
   logic [31:0] m_pc, m_ld, m_instret;
   int          n_cmp;
   int          n_fail;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic instr_t mk(input logic [31:0] word, input logic [6:0] cls, input logic taken,
                                 input logic [31:0] alu, input int iw, input int dw,
                                 input logic [31:0] rdata);
      instr_t d;
      d.word = word; d.cls = cls; d.taken = taken; d.alu = alu;
      d.iw = iw; d.dw = dw; d.rdata = rdata;
      return d;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk1({tag, "_imem_req"}, imem_req, 1'b0);
      chk1({tag, "_dmem_req"}, dmem_req, 1'b0);
      chk1({tag, "_dmem_we"}, dmem_we, 1'b0);
      chk1({tag, "_reg_we"}, reg_we, 1'b0);
      chk1({tag, "_halted"}, halted, 1'b0);
      chk32({tag, "_cause"}, {30'd0, trap_cause}, 32'd0);
      chk32({tag, "_pc"}, pc, 32'h0000_0000);
      chk32({tag, "_ir"}, ir, 32'h0000_0013);
      chk32({tag, "_instret"}, instret, 32'd0);
      chk32({tag, "_ld_data"}, ld_data, 32'd0);
      chk32({tag, "_dmem_addr"}, dmem_addr, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      {ctl_illegal, ctl_reg_write, ctl_jalr, ctl_jal, ctl_branch, ctl_store, ctl_load} = 7'd0;
      br_taken = 1'b0; alu_res = 32'd0;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;
      m_pc = 32'd0; m_instret = 32'd0; m_ld = 32'd0;
      @(negedge clk);
   endtask

   // Runs one instruction starting in a requesting FETCH cycle.
   task automatic run_instr(input instr_t d);
      logic [31:0] npc;
      logic [31:0] popped;
      logic        mis;
      logic        is_mem;
      wb_exp_t     e;
      int          n;
      {ctl_illegal, ctl_reg_write, ctl_jalr, ctl_jal, ctl_branch, ctl_store, ctl_load} = d.cls;
      br_taken = d.taken;
      alu_res  = d.alu;
      is_mem = d.cls[0] | d.cls[1];
      if (d.cls[4]) npc = d.alu & 32'hFFFF_FFFE;
      else if (d.cls[3] || (d.cls[2] && d.taken)) npc = d.alu;
      else npc = m_pc + 32'd4;
      mis = (npc[1:0] != 2'b00);
      e.we = d.cls[5] && !d.cls[1] && !(d.cls[2] && !d.cls[3] && !d.cls[4]) && !mis;
      e.ld = d.cls[0] ? d.rdata : m_ld;
      e.cycles = 3 + (is_mem ? 1 : 0) + d.iw + d.dw;
      fetch_q.push_back(m_pc);
      if (!d.cls[6]) wb_q.push_back(e);
      n = 0;
      for (int k = 0; k <= d.iw; k++) begin
         chk1("fetch_req", imem_req, 1'b1);
         if (k == d.iw) begin
            popped = fetch_q.pop_front();
            chk32("fetch_addr", imem_addr, popped);
         end
         imem_ready = (k == d.iw);
         imem_rdata = (k == d.iw) ? d.word : 32'hBAD0_BAD0;
         @(negedge clk); n++;
      end
      imem_ready = 1'b0;
      chk32("ir", ir, d.word);
      chk1("exec_imem_req", imem_req, 1'b0);
      chk1("exec_reg_we", reg_we, 1'b0);
      @(negedge clk); n++;
      if (d.cls[6]) begin
         chk1("ill_halted", halted, 1'b1);
         chk32("ill_cause", {30'd0, trap_cause}, 32'd1);
         chk1("ill_imem_req", imem_req, 1'b0);
         chk32("ill_pc", pc, m_pc);
         return;
      end
      if (is_mem) begin
         for (int k = 0; k <= d.dw; k++) begin
            chk1("mem_req", dmem_req, 1'b1);
            chk32("mem_addr", dmem_addr, d.alu);
            chk1("mem_we", dmem_we, d.cls[1]);
            dmem_ready = (k == d.dw);
            dmem_rdata = (k == d.dw) ? d.rdata : 32'h5A5A_5A5A;
            @(negedge clk); n++;
         end
         dmem_ready = 1'b0;
      end
      e = wb_q.pop_front();
      chk1("wb_reg_we", reg_we, e.we);
      chk32("wb_ld_data", ld_data, e.ld);
      chk1("wb_dmem_req", dmem_req, 1'b0);
      @(negedge clk); n++;
      chk32("cycles", 32'(n), 32'(e.cycles));
      chk1("post_reg_we", reg_we, 1'b0);
      m_ld = e.ld;
      if (mis) begin
         chk1("mis_halted", halted, 1'b1);
         chk32("mis_cause", {30'd0, trap_cause}, 32'd2);
         chk32("mis_pc", pc, m_pc);
         chk1("mis_imem_req", imem_req, 1'b0);
      end else begin
         m_pc = npc;
         m_instret = m_instret + 32'd1;
         chk32("pc", pc, m_pc);
         chk32("instret", instret, m_instret);
         chk1("next_fetch_req", imem_req, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
      {ctl_illegal, ctl_reg_write, ctl_jalr, ctl_jal, ctl_branch, ctl_store, ctl_load} = 7'd0;
      br_taken = 1'b0; alu_res = 32'd0;

      do_reset();
      for (int i = 0; i < 3; i++) run_instr(mk(32'h0010_0093, C_ALU, 1'b0, 32'h1, 0, 0, 32'd0));
      chk32("addi_instret", instret, 32'd3);
      run_instr(mk(32'h0000_A103, C_LD, 1'b0, 32'h0000_0100, 0, 2, 32'hDEAD_BEEF));
      run_instr(mk(32'h0020_A023, C_ST, 1'b0, 32'h0000_0104, 1, 0, 32'd0));
      run_instr(mk(32'h0000_0063, C_BRW, 1'b1, 32'h0000_0040, 0, 0, 32'd0));
      run_instr(mk(32'h0000_0063, C_BRW, 1'b0, 32'h0000_0080, 0, 0, 32'd0));
      run_instr(mk(32'h0000_00EF, C_JAL, 1'b0, 32'h0000_0200, 0, 0, 32'd0));
      run_instr(mk(32'h0000_80E7, C_JALR, 1'b0, 32'h0000_0103, 0, 0, 32'd0));
      imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("trap_halted", halted, 1'b1);
         chk1("trap_reg_we", reg_we, 1'b0);
         chk32("trap_pc", pc, 32'h0000_0200);
         chk32("trap_ir", ir, 32'h0000_80E7);
      end
      imem_ready = 1'b0;

      do_reset();
      run_instr(mk(32'h0010_0093, C_ALU, 1'b0, 32'h1, 0, 0, 32'd0));
      for (int i = 1; i <= 4; i++) begin
         chk1("wait_halted", halted, 1'b0);
         chk1("wait_imem_req", imem_req, 1'b1);
         @(negedge clk);
      end
      chk1("to_halted", halted, 1'b1);
      chk32("to_cause", {30'd0, trap_cause}, 32'd3);
      chk1("to_imem_req", imem_req, 1'b0);
      chk32("to_pc", pc, 32'h0000_0004);

      do_reset();
      run_instr(mk(32'hFFFF_FFFF, C_ILL, 1'b0, 32'd0, 0, 0, 32'd0));

      do_reset();
      run_instr(mk(32'h0010_0093, C_ALU, 1'b0, 32'h1, 0, 0, 32'd0));
      {ctl_illegal, ctl_reg_write, ctl_jalr, ctl_jal, ctl_branch, ctl_store, ctl_load} = C_LD;
      alu_res = 32'h0000_0300;
      imem_ready = 1'b1; imem_rdata = 32'h0000_A103;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      chk1("mid_mem_req1", dmem_req, 1'b1);
      @(negedge clk);
      chk1("mid_mem_req2", dmem_req, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      do_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
